// File: rtl/fifo_rx_stream_pkg.sv
// Shared definitions for the receive-FIFO stream reader: state encoding
// and default widths.
package fifo_rx_pkg;

  localparam int DW_DEF = 8;
  localparam int LW_DEF = 16;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] WORK  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

endpackage

// File: rtl/fifo_rx_stream_if.sv
// FIFO read port plus outgoing word stream. The master modport is the reader
// block; the slave modport is the FIFO/consumer side.
interface fifo_rx_stream_if
  import fifo_rx_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          fifo_empty;
  logic          fifo_rxen;
  logic [DW-1:0] fifo_rxd;
  logic [DW-1:0] rx_data;
  logic          rx_vld;
  logic          rx_sof;
  logic          rx_eof;

  modport master (
    input  fifo_empty, fifo_rxd,
    output fifo_rxen, rx_data, rx_vld, rx_sof, rx_eof
  );

  modport slave (
    output fifo_empty, fifo_rxd,
    input  fifo_rxen, rx_data, rx_vld, rx_sof, rx_eof
  );
endinterface

// File: rtl/fifo_rx_stream.sv
// Reads data_len words from a standard (1-cycle latency) FIFO on an fs
// request, forwards them as a valid/sof/eof stream and reports completion
// on fd. Optional macro FIFO_RX_STREAM_SUM_EN adds rx_sum, a 16-bit running
// sum of the words delivered in the current transfer.
module fifo_rx_stream
  import fifo_rx_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fs,
  output logic                    fd,
  input  logic [LW-1:0]           data_len,
  output logic                    busy,
  fifo_rx_stream_if.master        bus
`ifdef FIFO_RX_STREAM_SUM_EN
  ,
  output logic [15:0]             rx_sum
`endif
);

  localparam logic [LW-1:0] ONE = LW'(1);

  logic [2:0]    state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic          rd_p0;
  logic          last_p0;
  logic          vld_p1;
  logic          sof_p1;
  logic          eof_p1;

  // Stage p0: read request and position of the word being read this cycle.
  // len_q is never zero in WORK, so len_q-1 cannot wrap there.
  assign rd_p0   = (state == WORK) && !bus.fifo_empty;
  assign last_p0 = (len_q != '0) && (cnt == len_q - ONE);

  // Transfer sequencing: WAIT latches the length, WORK issues reads,
  // FLUSH lets the final read's data emerge, DONE holds fd until fs drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: state <= WAIT;
        WAIT: begin
          if (fs) begin
            len_q <= data_len;
            cnt   <= '0;
            state <= (data_len != '0) ? WORK : DONE;
          end
        end
        WORK: begin
          if (rd_p0) begin
            cnt <= cnt + ONE;
            if (last_p0) state <= FLUSH;
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          if (!fs) state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: stream qualifiers line up with the FIFO's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_p0;
      sof_p1 <= rd_p0 && (cnt == '0);
      eof_p1 <= rd_p0 && last_p0;
    end
  end

  assign bus.fifo_rxen = rd_p0;
  assign bus.rx_data   = bus.fifo_rxd;
  assign bus.rx_vld    = vld_p1;
  assign bus.rx_sof    = sof_p1;
  assign bus.rx_eof    = eof_p1;
  assign fd            = (state == DONE);
  assign busy          = (state == WORK) || (state == FLUSH);

`ifdef FIFO_RX_STREAM_SUM_EN
  logic [15:0] sum_q;

  function automatic logic [15:0] fit16(input logic [DW-1:0] w);
    logic [DW+15:0] t;
    t = {16'd0, w};
    return t[15:0];
  endfunction

  // Running modulo-2^16 sum; cleared when a transfer starts, held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if ((state == WAIT) && fs) begin
      sum_q <= '0;
    end else if (vld_p1) begin
      sum_q <= sum_q + fit16(bus.fifo_rxd);
    end
  end

  assign rx_sum = sum_q;
`endif

endmodule
